// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant owner and access sizes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_strobe_gen.sv
// Combinational byte-strobe, write-lane replication and misalignment detection for data accesses.
module mem_strobe_gen
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  always_comb begin
    wstrb      = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      // SZ_WORD, and the unused encoding treated as a word
      default: begin
        wstrb      = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory.
// Define MEM_ARBITER_RR_EN for round-robin on conflict; otherwise data has fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [1:0]        dm_size,
  output logic              dm_ready,
  output logic              dm_err,
  output logic [31:0]       dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t      state, state_d;
  logic        kill_q, kill_d;
  logic        err_q, err_d;
  logic        grant_if, grant_dm;
  logic        if_pend, dm_pend;
  logic [3:0]  dm_strb;
  logic [31:0] dm_wrep;
  logic        dm_misal;

`ifdef MEM_ARBITER_RR_EN
  owner_t last_q;
`endif

  mem_strobe_gen u_strobe (
    .addr_lo    (dm_addr[1:0]),
    .size       (dm_size),
    .wdata      (dm_wdata),
    .wstrb      (dm_strb),
    .wdata_rep  (dm_wrep),
    .misaligned (dm_misal)
  );

  // A fetch is never granted under kill; a data request is blocked while its error pulse is out.
  assign if_pend = if_req && !if_kill;
  assign dm_pend = dm_req && !err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    kill_d   = kill_q;
    err_d    = 1'b0;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state)
      IDLE: begin
`ifdef MEM_ARBITER_RR_EN
        if (if_pend && dm_pend) begin
          grant_dm = (last_q == OWN_IF);
          grant_if = (last_q == OWN_DM);
        end else begin
          grant_dm = dm_pend;
          grant_if = if_pend;
        end
`else
        grant_dm = dm_pend;
        grant_if = if_pend && !dm_pend;
`endif
        if (grant_dm) begin
          if (dm_misal) err_d   = 1'b1;
          else          state_d = BUSY_D;
        end else if (grant_if) begin
          state_d = BUSY_I;
          kill_d  = 1'b0;
        end
      end
      BUSY_I: begin
        kill_d = kill_q || if_kill;
        if (mem_ack) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      BUSY_D: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side request registers, loaded only at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      kill_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
    end else begin
      kill_q <= kill_d;
      err_q  <= err_d;
      if (grant_dm && !dm_misal) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr & WORD_MASK;
        mem_wdata <= dm_wrep;
        mem_wstrb <= dm_we ? dm_strb : 4'b0000;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr & WORD_MASK;
        mem_wdata <= '0;
        mem_wstrb <= 4'b0000;
      end else if (mem_ack && state != IDLE) begin
        mem_req <= 1'b0;
      end
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge clk) begin
    if (rst)           last_q <= OWN_IF;
    else if (grant_dm) last_q <= OWN_DM;
    else if (grant_if) last_q <= OWN_IF;
  end
`endif

  // Ready pulses follow the ack directly; an ack seen under reset is ignored.
  assign if_ready = (state == BUSY_I) && mem_ack && !kill_q && !if_kill && !rst;
  assign dm_ready = (((state == BUSY_D) && mem_ack) || err_q) && !rst;
  assign dm_err   = err_q && !rst;
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow MEM_ARBITER_RR_EN when defined.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_kill, if_ready;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              dm_req, dm_we, dm_ready, dm_err;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata, dm_rdata;
  logic [1:0]        dm_size;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_wstrb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_size(dm_size), .dm_ready(dm_ready), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change there and outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  logic        exp_dm [3];
  logic [31:0] exp_addr;

  initial begin
`ifdef MEM_ARBITER_RR_EN
    exp_dm[0] = 1'b1; exp_dm[1] = 1'b0; exp_dm[2] = 1'b1;
`else
    exp_dm[0] = 1'b1; exp_dm[1] = 1'b1; exp_dm[2] = 1'b1;
`endif
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_size = 2'b00;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    chk("rst_dm_err", 32'(dm_err), 32'd0);
    step(); rst = 1'b0;

    // Lone fetch at 0x100, ack one cycle after mem_req
    step(); if_req = 1'b1; if_addr = 32'h100;
    step(); #1;
    chk("if_mem_req", 32'(mem_req), 32'd1);
    chk("if_mem_addr", mem_addr, 32'h100);
    chk("if_mem_we", 32'(mem_we), 32'd0);
    chk("if_ready_early", 32'(if_ready), 32'd0);
    step(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("if_ready_ack", 32'(if_ready), 32'd1);
    chk("if_rdata", if_rdata, 32'hDEADBEEF);
    chk("if_mem_req_ack", 32'(mem_req), 32'd1);
    step(); mem_ack = 1'b0; if_req = 1'b0; #1;
    chk("if_mem_req_drop", 32'(mem_req), 32'd0);
    chk("if_ready_after", 32'(if_ready), 32'd0);

    // Three rounds of simultaneous fetch/data requests
    for (int r = 0; r < 3; r++) begin
      step();
      if_req = 1'b1; if_addr = 32'h300;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_size = 2'b10;
      step(); #1;
      exp_addr = exp_dm[r] ? 32'h400 : 32'h300;
      chk($sformatf("arb%0d_addr", r), mem_addr, exp_addr);
      chk($sformatf("arb%0d_req", r), 32'(mem_req), 32'd1);
      step(); mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(r); #1;
      chk($sformatf("arb%0d_rdy", r), {30'd0, if_ready, dm_ready},
          exp_dm[r] ? 32'd1 : 32'd2);
      step(); mem_ack = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    end

    // Byte store 0xAB at 0x203
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h203; dm_size = 2'b00; dm_wdata = 32'h000000AB;
    step(); #1;
    chk("sb_addr", mem_addr, 32'h200);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_we", 32'(mem_we), 32'd1);
    step(); mem_ack = 1'b1; #1;
    chk("sb_ready", {31'd0, dm_ready}, 32'd1);
    chk("sb_err", 32'(dm_err), 32'd0);
    step(); mem_ack = 1'b0; dm_req = 1'b0; #1;
    chk("sb_req_drop", 32'(mem_req), 32'd0);

    // Halfword store 0x1234 at 0x0A
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0A; dm_size = 2'b01; dm_wdata = 32'h55551234;
    step(); #1;
    chk("sh_addr", mem_addr, 32'h08);
    chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    step(); mem_ack = 1'b1; #1;
    chk("sh_ready", 32'(dm_ready), 32'd1);
    step(); mem_ack = 1'b0; dm_req = 1'b0;

    // Misaligned word load at 0x102
    step(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h102; dm_size = 2'b10; #1;
    chk("mis_n_ready", 32'(dm_ready), 32'd0);
    step(); #1;
    chk("mis_mem_req", 32'(mem_req), 32'd0);
    chk("mis_ready", 32'(dm_ready), 32'd1);
    chk("mis_err", 32'(dm_err), 32'd1);
    dm_req = 1'b0;
    step(); #1;
    chk("mis_ready_drop", {30'd0, dm_ready, dm_err}, 32'd0);
    chk("mis_mem_req2", 32'(mem_req), 32'd0);

    // Fetch killed during BUSY_I
    step(); if_req = 1'b1; if_addr = 32'h500;
    step(); if_kill = 1'b1; #1;
    chk("kill_mem_req", 32'(mem_req), 32'd1);
    step(); if_kill = 1'b0; mem_ack = 1'b1; #1;
    chk("kill_req_ack", 32'(mem_req), 32'd1);
    chk("kill_if_ready", 32'(if_ready), 32'd0);
    step(); mem_ack = 1'b0; if_req = 1'b0; #1;
    chk("kill_req_drop", 32'(mem_req), 32'd0);
    chk("kill_if_ready2", 32'(if_ready), 32'd0);

    // No fetch grant while if_kill is high
    step(); if_req = 1'b1; if_addr = 32'h540; if_kill = 1'b1;
    step(); #1;
    chk("kill_nogrant", 32'(mem_req), 32'd0);
    if_req = 1'b0; if_kill = 1'b0;

    // Reset in BUSY_D before ack, with an ack arriving during reset
    step(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600; dm_size = 2'b10;
    step(); #1;
    chk("rstd_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1; mem_ack = 1'b1; #1;
    chk("rstd_no_ready", 32'(dm_ready), 32'd0);
    step(); #1;
    chk("rstd_req_drop", 32'(mem_req), 32'd0);
    chk("rstd_no_ready2", 32'(dm_ready), 32'd0);
    rst = 1'b0; mem_ack = 1'b0; dm_req = 1'b0;
    step(); #1;
    chk("rstd_idle_req", 32'(mem_req), 32'd0);
    if_req = 1'b1; if_addr = 32'h700;
    step(); #1;
    chk("rstd_post_req", 32'(mem_req), 32'd1);
    chk("rstd_post_addr", mem_addr, 32'h700);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    chk("rstd_post_ready", 32'(if_ready), 32'd1);
    step(); mem_ack = 1'b0; if_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width of all address ports.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port if_req, input, 1, instruction-fetch read request.
REQ-005 SHALL have port if_addr, input, ADDR_W, fetch byte address.
REQ-006 SHALL have port if_kill, input, 1, taken-branch flush that discards fetch results.
REQ-007 SHALL have port if_ready, output, 1, one-cycle pulse marking valid if_rdata.
REQ-008 SHALL have port if_rdata, output, 32, fetched word.
REQ-009 SHALL have ports dm_req (in, 1), dm_we (in, 1), dm_addr (in, ADDR_W), dm_wdata (in, 32) and dm_size (in, 2; 00 byte, 01 half, 10 word) for the data-memory request.
REQ-010 SHALL have ports dm_ready (out, 1; completion pulse), dm_err (out, 1; misalignment flag, valid with dm_ready) and dm_rdata (out, 32; raw word).
REQ-011 SHALL have ports mem_req, mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, 32), mem_wstrb (out, 4), mem_ack (in, 1) and mem_rdata (in, 32) for the shared single-port memory.

Function
REQ-012 SHALL implement FSM IDLE, BUSY_I and BUSY_D; IDLE grants a pending request, and BUSY_x returns to IDLE on mem_ack.
REQ-013 SHALL, on a grant in cycle N, register address, data and strobes and assert mem_req from cycle N+1 until and including the mem_ack cycle.
REQ-014 SHALL drive mem_addr as the requester address with bits [1:0] cleared.
REQ-015 SHALL replicate write data to all lanes for byte and halfword writes, and shift mem_wstrb by addr[1:0] (byte 0001, half 0011, word 1111).
REQ-016 SHALL drive if_ready = mem_ack in BUSY_I (suppressed per REQ-019) and dm_ready = mem_ack in BUSY_D, with rdata passed through combinationally from mem_rdata.
REQ-017 SHALL, when both requests are present in IDLE, grant per REQ-026/027; a single request is always granted.
REQ-018 SHALL detect misalignment (half with addr[0]=1; word with addr[1:0]!=0) in IDLE, issue no memory access, and pulse dm_ready with dm_err=1 in cycle N+1.
REQ-019 SHALL latch a kill flag when if_kill is seen in BUSY_I or in its grant cycle, suppressing that transaction's if_ready while still completing the memory access.
REQ-020 SHALL NOT grant if_req in a cycle where if_kill=1.
REQ-021 SHALL treat requesters as holding req/addr/data stable until their ready pulse; inputs are sampled only at grant.
REQ-022 SHALL have a minimum latency of 2 cycles from request to ready, with no grant in the ack cycle; back-to-back grants therefore have a 1-cycle IDLE gap.

Reset
REQ-023 SHALL, on rst, force IDLE and clear the kill flag, zero mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ready, dm_ready and dm_err, and set last_grant=IF.
REQ-024 SHALL, on rst asserted mid-transaction, drop mem_req the next cycle, emit no ready pulse, and ignore any mem_ack arriving during reset.

Configuration
REQ-025 SHALL use macro MEM_ARBITER_RR_EN to select the arbitration policy.
REQ-026 SHALL, with MEM_ARBITER_RR_EN defined, arbitrate round-robin on conflict: the requester not in last_grant wins, and last_grant updates on every grant.
REQ-027 SHALL, without MEM_ARBITER_RR_EN, give fixed priority to data over fetch, with last_grant unused.

Structure
REQ-028 SHALL place the state enum, the owner enum (OWN_IF, OWN_DM) and the size encodings SZ_BYTE, SZ_HALF, SZ_WORD in package mem_arbiter_pkg.
REQ-029 SHALL put strobe, lane replication and misalignment logic in combinational sub-module mem_strobe_gen.

Verification
REQ-030 SHALL cover: if_req at 0x100 alone, ack 1 cycle after mem_req -> mem_addr=0x100, if_ready at N+2 with mem_rdata.
REQ-031 SHALL cover: byte store 0xAB to 0x203 -> mem_wstrb=1000, mem_wdata=0xABABABAB, mem_addr=0x200.
REQ-032 SHALL cover: simultaneous if_req/dm_req over three rounds -> fixed build always grants DM; RR build grants DM, IF, DM.
REQ-033 SHALL cover: word load at 0x102 -> no mem_req, dm_ready=1 and dm_err=1 at N+1.
REQ-034 SHALL cover: if_kill during BUSY_I -> mem_req completes on ack and if_ready stays 0.
REQ-035 SHALL cover: rst asserted in BUSY_D before ack -> state IDLE, mem_req=0 next cycle, no dm_ready.
